// File: rtl/msi_pkg.sv
// Purpose: shared types for the MSI cache controllers (line states, FSM states, bus commands).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msi_pkg;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } msi_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARBITRATE,
        ST_WRITE_BACK,
        ST_FILL,
        ST_INVALIDATE
    } ctrl_state_t;

    // Bus command vector, ordered {invalidate, write, read_exclusive, read}; at most one bit set.
    localparam logic [3:0] BUS_CMD_NONE  = 4'b0000;
    localparam logic [3:0] BUS_CMD_READ  = 4'b0001;
    localparam logic [3:0] BUS_CMD_READX = 4'b0010;
    localparam logic [3:0] BUS_CMD_WRITE = 4'b0100;
    localparam logic [3:0] BUS_CMD_INV   = 4'b1000;

endpackage

// File: rtl/line_word_counter.sv
// Purpose: word-within-line counter for write-back / fill bursts, with last-word flag.
// Latency: count updates one cycle after increment; last is combinational from count.
// Backpressure: advances only on increment (bus ack); clear has priority and wraps naturally.
module line_word_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // Count acknowledged words; clear/reset return to word 0, last word wraps to 0.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (increment) begin
            count <= count + 1'b1;
        end
    end

    assign last = &count;

endmodule

// File: rtl/msi_cpu_cache_controller.sv
// Purpose: CPU-side MSI write-back/write-allocate controller mastering one port of a direct-mapped cache.
// Latency: hits complete in the request cycle; misses take 2 + N (clean) or 2 + 2N (dirty victim) bus words plus waits.
// Backpressure: CPU request held until cpuFunctionComplete; bus words advance only on busAck, bus access only after busGrant.
module msi_cpu_cache_controller
    import msi_pkg::*;
#(
    parameter int TAG_WIDTH    = 8,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpuAddress,
    input  logic                                          cpuRead,
    input  logic                                          cpuWrite,
    input  logic [DATA_WIDTH-1:0]                         cpuDataIn,
    output logic [DATA_WIDTH-1:0]                         cpuDataOut,
    output logic                                          cpuFunctionComplete,
    output logic [INDEX_WIDTH-1:0]                        cacheIndex,
    output logic [OFFSET_WIDTH-1:0]                       cacheOffset,
    output logic [TAG_WIDTH-1:0]                          cacheTagOut,
    input  logic [TAG_WIDTH-1:0]                          cacheTagIn,
    input  logic                                          cacheHit,
    input  logic [1:0]                                    cacheStateIn,
    output logic [1:0]                                    cacheStateOut,
    input  logic [DATA_WIDTH-1:0]                         cacheDataIn,
    output logic [DATA_WIDTH-1:0]                         cacheDataOut,
    output logic                                          cacheWriteTag,
    output logic                                          cacheWriteState,
    output logic                                          cacheWriteData,
    output logic                                          busRequest,
    input  logic                                          busGrant,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
    output logic                                          busRead,
    output logic                                          busReadExclusive,
    output logic                                          busWrite,
    output logic                                          busInvalidate,
    output logic [DATA_WIDTH-1:0]                         busDataOut,
    input  logic [DATA_WIDTH-1:0]                         busDataIn,
    input  logic                                          busAck
);

    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    ctrl_state_t             state;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic                    req_write;
    logic [3:0]              bus_cmd;
    logic [OFFSET_WIDTH-1:0] word_count;
    logic                    word_last;

    logic [TAG_WIDTH-1:0]    cpu_tag;
    logic [INDEX_WIDTH-1:0]  cpu_index;
    logic [OFFSET_WIDTH-1:0] cpu_offset;
    logic                    cpu_req;
    logic                    idle_serve;
    logic                    in_burst;

    assign cpu_tag    = cpuAddress[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
    assign cpu_index  = cpuAddress[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign cpu_offset = cpuAddress[OFFSET_WIDTH-1:0];
    assign cpu_req    = cpuRead | cpuWrite;

    // A request present in IDLE is served locally when it hits and, for a write, the line is already owned.
    assign idle_serve = cacheHit && (!cpuWrite || (cacheStateIn == MODIFIED));
    assign in_burst   = (state == ST_WRITE_BACK) || (state == ST_FILL);

    assign {busInvalidate, busWrite, busReadExclusive, busRead} = bus_cmd;

    line_word_counter #(
        .WIDTH (OFFSET_WIDTH)
    ) u_word_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (!in_burst),
        .increment (in_burst && busAck),
        .count     (word_count),
        .last      (word_last)
    );

    // Control FSM; the request is latched on leaving IDLE so a dropped request still finishes its fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            req_offset <= '0;
            req_write  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req && !idle_serve) begin
                        state      <= ST_ARBITRATE;
                        req_tag    <= cpu_tag;
                        req_index  <= cpu_index;
                        req_offset <= cpu_offset;
                        req_write  <= cpuWrite;
                    end
                end
                ST_ARBITRATE: begin
                    // The snooper may have touched the line while we waited, so decide on the live lookup.
                    if (busGrant) begin
                        if (cacheHit && req_write && (cacheStateIn == SHARED)) begin
                            state <= ST_INVALIDATE;
                        end else if (cacheHit) begin
                            state <= ST_IDLE;
                        end else if (cacheStateIn == MODIFIED) begin
                            state <= ST_WRITE_BACK;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_WRITE_BACK: begin
                    if (busAck && word_last) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (busAck && word_last) begin
                        state <= ST_IDLE;
                    end
                end
                ST_INVALIDATE: begin
                    if (busAck) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and live inputs; everything is forced low while reset is high.
    always_comb begin
        cpuDataOut          = '0;
        cpuFunctionComplete = 1'b0;
        cacheIndex          = '0;
        cacheOffset         = '0;
        cacheTagOut         = '0;
        cacheStateOut       = '0;
        cacheDataOut        = '0;
        cacheWriteTag       = 1'b0;
        cacheWriteState     = 1'b0;
        cacheWriteData      = 1'b0;
        busRequest          = 1'b0;
        busAddress          = '0;
        busDataOut          = '0;
        bus_cmd             = BUS_CMD_NONE;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        cacheIndex  = cpu_index;
                        cacheOffset = cpu_offset;
                        cacheTagOut = cpu_tag;
                        if (cacheHit && !cpuWrite) begin
                            cpuDataOut          = cacheDataIn;
                            cpuFunctionComplete = 1'b1;
                        end else if (cacheHit && (cacheStateIn == MODIFIED)) begin
                            cacheWriteData      = 1'b1;
                            cacheDataOut        = cpuDataIn;
                            cpuFunctionComplete = 1'b1;
                        end else begin
                            busRequest = 1'b1;
                        end
                    end
                end
                ST_ARBITRATE: begin
                    busRequest  = 1'b1;
                    cacheIndex  = req_index;
                    cacheOffset = req_offset;
                    cacheTagOut = req_tag;
                end
                ST_WRITE_BACK: begin
                    busRequest  = 1'b1;
                    bus_cmd     = BUS_CMD_WRITE;
                    cacheIndex  = req_index;
                    cacheOffset = word_count;
                    cacheTagOut = req_tag;
                    busAddress  = {cacheTagIn, req_index, word_count};
                    busDataOut  = cacheDataIn;
                end
                ST_FILL: begin
                    busRequest  = 1'b1;
                    bus_cmd     = req_write ? BUS_CMD_READX : BUS_CMD_READ;
                    cacheIndex  = req_index;
                    cacheOffset = word_count;
                    cacheTagOut = req_tag;
                    busAddress  = {req_tag, req_index, word_count};
                    if (busAck) begin
                        cacheWriteData = 1'b1;
                        cacheDataOut   = busDataIn;
                        if (word_last) begin
                            cacheWriteTag   = 1'b1;
                            cacheWriteState = 1'b1;
                            cacheStateOut   = req_write ? MODIFIED : SHARED;
                        end
                    end
                end
                ST_INVALIDATE: begin
                    busRequest  = 1'b1;
                    bus_cmd     = BUS_CMD_INV;
                    cacheIndex  = req_index;
                    cacheOffset = req_offset;
                    cacheTagOut = req_tag;
                    busAddress  = {req_tag, req_index, req_offset};
                    if (busAck) begin
                        cacheWriteState     = 1'b1;
                        cacheStateOut       = MODIFIED;
                        cacheWriteData      = 1'b1;
                        cacheDataOut        = cpuDataIn;
                        cpuFunctionComplete = 1'b1;
                    end
                end
                default: begin
                    busRequest = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msi_cpu_cache_controller.sv
// Purpose: randomized bench for the CPU-side MSI controller with cache storage, arbiter and memory models.
// Latency: checks zero-cycle hits and exact bus word counts per request against a flat coherent-memory model.
// Backpressure: grant and ack are randomly delayed; every wait is bounded.
module tb_msi_cpu_cache_controller;
    import msi_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] cpuAddress;
    logic        cpuRead, cpuWrite;
    logic [31:0] cpuDataIn, cpuDataOut;
    logic        cpuFunctionComplete;
    logic [3:0]  cacheIndex;
    logic [1:0]  cacheOffset;
    logic [7:0]  cacheTagOut, cacheTagIn;
    logic        cacheHit;
    logic [1:0]  cacheStateIn, cacheStateOut;
    logic [31:0] cacheDataIn, cacheDataOut;
    logic        cacheWriteTag, cacheWriteState, cacheWriteData;
    logic        busRequest;
    logic        busGrant = 1'b0;
    logic [13:0] busAddress;
    logic        busRead, busReadExclusive, busWrite, busInvalidate;
    logic [31:0] busDataOut, busDataIn;
    logic        busAck;

    always #5 clock = ~clock;

    msi_cpu_cache_controller dut (
        .clock (clock), .reset (reset),
        .cpuAddress (cpuAddress), .cpuRead (cpuRead), .cpuWrite (cpuWrite),
        .cpuDataIn (cpuDataIn), .cpuDataOut (cpuDataOut), .cpuFunctionComplete (cpuFunctionComplete),
        .cacheIndex (cacheIndex), .cacheOffset (cacheOffset), .cacheTagOut (cacheTagOut),
        .cacheTagIn (cacheTagIn), .cacheHit (cacheHit), .cacheStateIn (cacheStateIn),
        .cacheStateOut (cacheStateOut), .cacheDataIn (cacheDataIn), .cacheDataOut (cacheDataOut),
        .cacheWriteTag (cacheWriteTag), .cacheWriteState (cacheWriteState), .cacheWriteData (cacheWriteData),
        .busRequest (busRequest), .busGrant (busGrant), .busAddress (busAddress),
        .busRead (busRead), .busReadExclusive (busReadExclusive), .busWrite (busWrite),
        .busInvalidate (busInvalidate), .busDataOut (busDataOut), .busDataIn (busDataIn), .busAck (busAck)
    );

    // Cache storage, main memory and bench controls.
    logic [31:0] mem     [0:16383];
    logic [7:0]  tag_arr [0:15];
    logic [1:0]  st_arr  [0:15];
    logic [31:0] dat_arr [0:63];
    logic        init_mem, hold_grant, snoop_inv;
    logic [3:0]  snoop_idx;
    logic        ack_en = 1'b0;
    int wr_total = 0, rd_total = 0, rdx_total = 0, inv_total = 0, cmp_total = 0;

    // Reference model: flat coherent memory plus which line is resident in each set.
    logic [31:0] ref_mem [0:16383];
    logic [7:0]  m_tag   [0:15];
    msi_state_t  m_state [0:15];

    int n_cmp = 0;
    int n_err = 0;
    int n_req = 0;

    function automatic logic [31:0] mem_init(input int a);
        return 32'h5A00_0000 ^ (a * 32'h0001_9E37);
    endfunction

    assign cacheTagIn   = tag_arr[cacheIndex];
    assign cacheStateIn = st_arr[cacheIndex];
    assign cacheDataIn  = dat_arr[{cacheIndex, cacheOffset}];
    assign cacheHit     = (tag_arr[cacheIndex] == cacheTagOut) && (st_arr[cacheIndex] != INVALID);
    assign busDataIn    = mem[busAddress];
    assign busAck       = ack_en && (busRead || busReadExclusive || busWrite || busInvalidate);

    // Storage/memory updates, random arbiter and bus slave, transfer counters.
    always @(posedge clock) begin
        if (init_mem) begin
            for (int a = 0; a < 16384; a++) mem[a] <= mem_init(a);
            for (int i = 0; i < 16; i++) begin
                tag_arr[i] <= '0;
                st_arr[i]  <= INVALID;
            end
            for (int i = 0; i < 64; i++) dat_arr[i] <= '0;
        end else begin
            if (cacheWriteData) dat_arr[{cacheIndex, cacheOffset}] <= cacheDataOut;
            if (cacheWriteTag) tag_arr[cacheIndex] <= cacheTagOut;
            if (cacheWriteState) st_arr[cacheIndex] <= cacheStateOut;
            else if (snoop_inv) st_arr[snoop_idx] <= INVALID;
            if (busAck && busWrite) mem[busAddress] <= busDataOut;
        end
        if (reset) busGrant <= 1'b0;
        else busGrant <= busRequest && !hold_grant && (busGrant || ($urandom_range(0, 2) == 0));
        ack_en <= ($urandom_range(0, 1) == 1);
        if (busAck && busWrite)         wr_total  <= wr_total + 1;
        if (busAck && busRead)          rd_total  <= rd_total + 1;
        if (busAck && busReadExclusive) rdx_total <= rdx_total + 1;
        if (busAck && busInvalidate)    inv_total <= inv_total + 1;
        if (cpuFunctionComplete)        cmp_total <= cmp_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{cpuDataOut, cpuFunctionComplete, cacheIndex, cacheOffset, cacheTagOut, cacheStateOut,
                 cacheDataOut, cacheWriteTag, cacheWriteState, cacheWriteData, busRequest, busAddress,
                 busRead, busReadExclusive, busWrite, busInvalidate, busDataOut};
    endfunction

    // One CPU request; expectations come from the MSI rules applied to the model, not from the DUT.
    task automatic do_req(input logic wr, input logic both, input logic [13:0] addr,
                          input logic [31:0] data, input logic snoop);
        logic [3:0]  idx;
        logic [7:0]  tg;
        logic        resident, exp_fast, exp_inv, victim, done, saw_req;
        logic [31:0] got;
        int          exp_fill, exp_wb, cycles;
        int          wr0, rd0, rdx0, inv0, cmp0;
        idx = addr[5:2];
        tg  = addr[13:6];
        if (snoop) m_state[idx] = INVALID;
        resident = (m_state[idx] != INVALID) && (m_tag[idx] == tg);
        exp_fast = resident && (!wr || m_state[idx] == MODIFIED);
        exp_inv  = resident && wr && (m_state[idx] == SHARED);
        victim   = !resident && (m_state[idx] == MODIFIED);
        exp_wb   = victim ? 4 : 0;
        exp_fill = resident ? 0 : 4;
        wr0 = wr_total; rd0 = rd_total; rdx0 = rdx_total; inv0 = inv_total; cmp0 = cmp_total;
        hold_grant = snoop;
        snoop_idx  = idx;
        cpuAddress = addr;
        cpuRead    = !wr || both;
        cpuWrite   = wr;
        cpuDataIn  = data;
        cycles = 0; done = 1'b0; saw_req = 1'b0; got = '0;
        while (!done && cycles < 400) begin
            #1;
            if (cpuFunctionComplete) begin
                done = 1'b1;
                got  = cpuDataOut;
            end else if (busRequest) begin
                saw_req = 1'b1;
            end
            @(negedge clock);
            if (!done) cycles++;
            if (snoop && cycles == 1) snoop_inv = 1'b1;
            if (snoop && cycles == 2) begin
                snoop_inv  = 1'b0;
                hold_grant = 1'b0;
            end
        end
        cpuRead = 1'b0; cpuWrite = 1'b0;
        hold_grant = 1'b0; snoop_inv = 1'b0;
        n_req++;
        chk("req_done", done, 1'b1);
        if (exp_fast) begin
            chk("hit_latency", cycles, 0);
            chk("hit_no_busreq", saw_req, 1'b0);
        end
        chk("writeback_words", wr_total - wr0, exp_wb);
        chk("fill_read_words", rd_total - rd0, wr ? 0 : exp_fill);
        chk("fill_readx_words", rdx_total - rdx0, wr ? exp_fill : 0);
        chk("invalidates", inv_total - inv0, exp_inv);
        chk("complete_pulses", cmp_total - cmp0, 1);
        if (!wr) chk("read_data", got, ref_mem[addr]);
        if (!resident) m_state[idx] = SHARED;
        m_tag[idx] = tg;
        if (wr) begin
            m_state[idx] = MODIFIED;
            ref_mem[addr] = data;
        end
    endtask

    // Read miss to an INVALID set, reset after the first fill word: bus abandoned, line untouched.
    task automatic reset_mid_fill();
        int rd0, n;
        rd0 = rd_total;
        n = 0;
        cpuAddress = {8'h07, 4'd3, 2'd1};
        cpuRead = 1'b1;
        cpuWrite = 1'b0;
        while ((rd_total - rd0) < 1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("rst_reached_fill", rd_total - rd0, 1);
        reset = 1'b1;
        cpuRead = 1'b0;
        cpuAddress = '0;
        #1;
        chk("rst_busreq_same_cycle", busRequest, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_outputs_zero", any_out(), 1'b0);
        repeat (3) @(negedge clock);
        chk("rst_fill_abandoned", rd_total - rd0, 1);
        chk("rst_line_state", st_arr[3], INVALID);
    endtask

    initial begin
        reset = 1'b1; init_mem = 1'b1; hold_grant = 1'b0; snoop_inv = 1'b0; snoop_idx = '0;
        cpuAddress = '0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuDataIn = '0;
        for (int a = 0; a < 16384; a++) ref_mem[a] = mem_init(a);
        for (int i = 0; i < 16; i++) begin
            m_tag[i] = '0;
            m_state[i] = INVALID;
        end
        repeat (3) @(negedge clock);
        init_mem = 1'b0;
        #1;
        chk("reset_outputs", any_out(), 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("idle_outputs", any_out(), 1'b0);
        @(negedge clock);

        // Cold read of 0x0A4, hit at offset 3, SHARED write hit, dirty-victim write miss.
        do_req(1'b0, 1'b0, 14'h0A4, 32'h0, 1'b0);
        chk("cold_tag", tag_arr[9], 8'h02);
        chk("cold_state", st_arr[9], SHARED);
        do_req(1'b0, 1'b0, 14'h0A7, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 14'h0A5, 32'hDEADBEEF, 1'b0);
        chk("inv_state", st_arr[9], MODIFIED);
        chk("inv_data", dat_arr[{4'd9, 2'd1}], 32'hDEADBEEF);
        do_req(1'b1, 1'b0, {8'h05, 4'd9, 2'd2}, 32'h1234_5678, 1'b0);
        chk("wb_data_in_mem", mem[{8'h02, 4'd9, 2'd1}], 32'hDEADBEEF);
        chk("wm_tag", tag_arr[9], 8'h05);
        chk("wm_state", st_arr[9], MODIFIED);

        reset_mid_fill();

        // Snooper kills a SHARED line while the write waits for the bus.
        do_req(1'b0, 1'b0, {8'h01, 4'd4, 2'd0}, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, {8'h01, 4'd4, 2'd3}, 32'hCAFE_F00D, 1'b1);
        chk("snoop_state", st_arr[4], MODIFIED);

        for (int k = 0; k < 150; k++) begin
            logic        w, b;
            logic [13:0] a;
            w = ($urandom_range(0, 1) == 1);
            b = w && ($urandom_range(0, 4) == 0);
            a = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(w, b, a, $urandom, 1'b0);
        end

        repeat (5) @(negedge clock);
        chk("total_completes", cmp_total, n_req);
        for (int i = 0; i < 16; i++) begin
            chk("line_state", st_arr[i], m_state[i]);
            if (m_state[i] != INVALID) chk("line_tag", tag_arr[i], m_tag[i]);
        end
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 64; i++) begin
                logic [13:0] a;
                logic [31:0] v;
                a = {8'(t), 6'(i)};
                v = (st_arr[i / 4] == MODIFIED && tag_arr[i / 4] == 8'(t)) ? dat_arr[i] : mem[a];
                chk("coherent_word", v, ref_mem[a]);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
